// File: rtl/dwconv_channel_scheduler.sv
// Streams one feature-map channel at a time from activation SRAM into the 3x3 line buffer,
// framing each channel with start_frame and waiting for its windows before moving on.
module dwconv_channel_scheduler #(
  parameter int IMAGE_WIDTH   = 224,
  parameter int IMAGE_HEIGHT  = 224,
  parameter int ADDR_W        = 20,
  parameter int CH_W          = 10,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CH_W-1:0]   num_channels,
  input  logic              sink_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid,
  output logic              start_frame,
  input  logic              window_valid_in,
  output logic [CH_W-1:0]   channel_idx,
  output logic              channel_done,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int FRAME_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int WIN_EXP   = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam int DRN_W     = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  LAST_PIX     = CNT_W'(FRAME_PIX - 1);
  localparam logic [CNT_W-1:0]  WIN_TARGET   = CNT_W'(WIN_EXP);
  localparam logic [DRN_W-1:0]  DRAIN_LAST   = DRN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(FRAME_PIX);

  typedef enum logic [2:0] {
    IDLE, FRAME_START, STREAM, DRAIN, CH_DONE, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] addr;
  logic [CH_W-1:0]   num_ch_q;
  logic [CH_W-1:0]   channel_idx_q;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  win_cnt;
  logic [DRN_W-1:0]  drain_cnt;
  logic              error_q;
  logic              pixel_valid_q;

  // Read strobe is gated combinationally so a deasserted sink_ready, an abort or a reset
  // stops the SRAM access in the same cycle.
  assign mem_rd_en    = (state == STREAM) && sink_ready && !abort && !reset;
  assign mem_rd_addr  = addr;
  assign pixel_out    = mem_rd_data;
  assign pixel_valid  = pixel_valid_q;
  assign start_frame  = (state == FRAME_START);
  assign channel_done = (state == CH_DONE);
  assign done         = (state == DONE);
  assign busy         = (state != IDLE);
  assign channel_idx  = channel_idx_q;
  assign error        = error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      frame_base    <= '0;
      addr          <= '0;
      num_ch_q      <= '0;
      channel_idx_q <= '0;
      pix_cnt       <= '0;
      win_cnt       <= '0;
      drain_cnt     <= '0;
      error_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= mem_rd_en;

      if ((state == STREAM || state == DRAIN) && window_valid_in)
        win_cnt <= win_cnt + CNT_W'(1);

      if (state != IDLE && abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              num_ch_q      <= num_channels;
              frame_base    <= base_addr;
              channel_idx_q <= '0;
              error_q       <= 1'b0;
              state         <= (num_channels == '0) ? DONE : FRAME_START;
            end
          end
          FRAME_START: begin
            addr      <= frame_base;
            pix_cnt   <= '0;
            win_cnt   <= '0;
            drain_cnt <= '0;
            state     <= STREAM;
          end
          STREAM: begin
            if (sink_ready) begin
              addr    <= addr + ADDR_W'(1);
              pix_cnt <= pix_cnt + CNT_W'(1);
              if (pix_cnt == LAST_PIX)
                state <= DRAIN;
            end
          end
          DRAIN: begin
            // A match in the same cycle as the timeout still counts as a clean channel.
            if (win_cnt == WIN_TARGET) begin
              state <= CH_DONE;
            end else if (drain_cnt == DRAIN_LAST) begin
              error_q <= 1'b1;
              state   <= CH_DONE;
            end else begin
              drain_cnt <= drain_cnt + DRN_W'(1);
            end
          end
          CH_DONE: begin
            if (channel_idx_q == num_ch_q - CH_W'(1)) begin
              state <= DONE;
            end else begin
              channel_idx_q <= channel_idx_q + CH_W'(1);
              frame_base    <= frame_base + FRAME_STRIDE;
              state         <= FRAME_START;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dwconv_channel_scheduler.sv
// Directed bench for dwconv_channel_scheduler with a 4x4 image, an SRAM model and a line-buffer model.
module tb_dwconv_channel_scheduler;

  localparam int W = 4;
  localparam int H = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [19:0] base_addr;
  logic [9:0]  num_channels;
  logic        sink_ready;
  logic        mem_rd_en;
  logic [19:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = 8'h00;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        start_frame;
  logic        window_valid_in;
  logic [9:0]  channel_idx;
  logic        channel_done;
  logic        busy;
  logic        done;
  logic        error;

  logic sr_level  = 1'b1;
  logic sr_toggle = 1'b0;
  logic phase     = 1'b0;
  logic wv_kill   = 1'b0;
  logic [3:0] lb_cnt = 4'd0;

  always #5 clock = ~clock;

  dwconv_channel_scheduler #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(20), .CH_W(10), .DRAIN_TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_channels(num_channels), .sink_ready(sink_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .start_frame(start_frame),
    .window_valid_in(window_valid_in), .channel_idx(channel_idx),
    .channel_done(channel_done), .busy(busy), .done(done), .error(error)
  );

  // SRAM model: one-cycle read latency, data derived from the address.
  always @(posedge clock) mem_rd_data <= mem_rd_en ? (mem_rd_addr[7:0] ^ 8'h5A) : 8'h00;

  // Line-buffer model: a window appears with every pixel at row>=2 and col>=2.
  always @(posedge clock) begin
    phase <= ~phase;
    if (start_frame) lb_cnt <= 4'd0;
    else if (pixel_valid) lb_cnt <= lb_cnt + 4'd1;
  end
  assign window_valid_in = pixel_valid && !wv_kill && (lb_cnt[1:0] >= 2'd2) && (lb_cnt[3:2] >= 2'd2);
  assign sink_ready = sr_toggle ? phase : sr_level;

  // Event monitor, sampled on the falling edge.
  int cyc = 0, busy_n = 0, rd_n = 0, pv_n = 0, sf_n = 0, cd_n = 0, done_n = 0;
  int viol_n = 0, pix_bad = 0;
  logic [19:0] last_rd_addr = '0;
  logic [19:0] rd_addrs[$];
  int          rd_cyc[$];
  logic [9:0]  sf_idx[$];

  always @(negedge clock) begin
    cyc++;
    if (busy) busy_n++;
    if (pixel_valid) begin
      pv_n++;
      if (pixel_out != (last_rd_addr[7:0] ^ 8'h5A)) pix_bad++;
    end
    if (mem_rd_en) begin
      rd_n++;
      rd_addrs.push_back(mem_rd_addr);
      rd_cyc.push_back(cyc);
      last_rd_addr = mem_rd_addr;
      if (!sink_ready) viol_n++;
    end
    if (start_frame) begin
      sf_n++;
      sf_idx.push_back(channel_idx);
    end
    if (channel_done) cd_n++;
    if (done) done_n++;
  end

  int n_chk = 0, n_fail = 0;
  int s_busy, s_rd, s_pv, s_sf, s_cd, s_done, s_viol, s_pixbad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_busy = busy_n; s_rd = rd_n; s_pv = pv_n; s_sf = sf_n; s_cd = cd_n; s_done = done_n;
    s_viol = viol_n; s_pixbad = pix_bad;
  endtask

  task automatic pulse_start(input logic [19:0] b, input logic [9:0] n);
    @(posedge clock); #1;
    start = 1'b1; base_addr = b; num_channels = n;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Waits for done, then lets the job's trailing events settle.
  task automatic wait_done(input string tag, input int limit);
    int found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (done) begin found = 1; break; end
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    @(negedge clock);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    @(negedge clock);
  endtask

  task automatic check_addrs(input string tag, input int idx, input logic [19:0] b, input int cnt);
    int bad;
    bad = 0;
    for (int i = 0; i < cnt; i++)
      if (idx + i >= rd_addrs.size() || rd_addrs[idx + i] != b + 20'(i)) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int q0, c0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; num_channels = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_flags", {26'd0, busy, done, mem_rd_en, pixel_valid, start_frame, channel_done},
          32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_chidx", 32'(channel_idx), 32'd0);

    // 1: single channel, sink always ready
    snap(); q0 = rd_addrs.size();
    pulse_start(20'h100, 10'd1);
    wait_done("t1", 40);
    check("t1_start_frames", 32'(sf_n - s_sf), 32'd1);
    check("t1_reads", 32'(rd_n - s_rd), 32'd16);
    check_addrs("t1_addr_seq", q0, 20'h100, 16);
    check("t1_b2b_span", 32'(rd_cyc[q0 + 15] - rd_cyc[q0]), 32'd15);
    check("t1_pixel_valid", 32'(pv_n - s_pv), 32'd16);
    check("t1_pixel_data_bad", 32'(pix_bad - s_pixbad), 32'd0);
    check("t1_ch_done", 32'(cd_n - s_cd), 32'd1);
    check("t1_done", 32'(done_n - s_done), 32'd1);
    check("t1_busy_cycles", 32'(busy_n - s_busy), 32'd21);
    check("t1_error", 32'(error), 32'd0);

    // 2: three contiguous channels from base 0
    snap(); q0 = rd_addrs.size(); c0 = sf_idx.size();
    pulse_start(20'h000, 10'd3);
    wait_done("t2", 100);
    check("t2_start_frames", 32'(sf_n - s_sf), 32'd3);
    check("t2_ch_done", 32'(cd_n - s_cd), 32'd3);
    check("t2_reads", 32'(rd_n - s_rd), 32'd48);
    check_addrs("t2_addr_seq", q0, 20'h000, 48);
    check("t2_frame1_addr", 32'(rd_addrs[q0 + 16]), 32'h010);
    check("t2_frame2_addr", 32'(rd_addrs[q0 + 32]), 32'h020);
    check("t2_idx0", 32'(sf_idx[c0]), 32'd0);
    check("t2_idx1", 32'(sf_idx[c0 + 1]), 32'd1);
    check("t2_idx2", 32'(sf_idx[c0 + 2]), 32'd2);
    check("t2_busy_cycles", 32'(busy_n - s_busy), 32'd61);

    // 3: sink_ready alternating
    sr_toggle = 1'b1;
    snap(); q0 = rd_addrs.size();
    pulse_start(20'h200, 10'd1);
    wait_done("t3", 80);
    sr_toggle = 1'b0;
    check("t3_reads", 32'(rd_n - s_rd), 32'd16);
    check("t3_read_when_not_ready", 32'(viol_n - s_viol), 32'd0);
    check_addrs("t3_addr_seq", q0, 20'h200, 16);
    check("t3_span", 32'(rd_cyc[q0 + 15] - rd_cyc[q0]), 32'd30);
    check("t3_pixel_valid", 32'(pv_n - s_pv), 32'd16);
    check("t3_error", 32'(error), 32'd0);

    // 4: no windows returned -> drain timeout
    wv_kill = 1'b1;
    snap();
    pulse_start(20'h000, 10'd1);
    wait_done("t4", 80);
    wv_kill = 1'b0;
    check("t4_error_set", 32'(error), 32'd1);
    check("t4_done", 32'(done_n - s_done), 32'd1);
    check("t4_busy_cycles", 32'(busy_n - s_busy), 32'd35);
    pulse_start(20'h000, 10'd1);
    @(negedge clock);
    check("t4_error_cleared", 32'(error), 32'd0);
    wait_done("t4b", 40);
    check("t4b_error", 32'(error), 32'd0);

    // 5a: abort after the 7th read
    snap();
    pulse_start(20'h000, 10'd2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #1;
      if (rd_n - s_rd >= 7) break;
    end
    @(posedge clock); #1 abort = 1'b1;
    #1 check("t5_rd_en_in_abort", 32'(mem_rd_en), 32'd0);
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock);
    check("t5_busy_after_abort", 32'(busy), 32'd0);
    repeat (5) @(negedge clock);
    check("t5_reads", 32'(rd_n - s_rd), 32'd7);
    check("t5_pixel_valid", 32'(pv_n - s_pv), 32'd7);
    check("t5_no_done", 32'(done_n - s_done), 32'd0);
    check("t5_no_ch_done", 32'(cd_n - s_cd), 32'd0);

    // 5b: reset in the middle of a job
    pulse_start(20'h040, 10'd2);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check("t5_rst_flags", {26'd0, busy, done, mem_rd_en, pixel_valid, start_frame, channel_done},
          32'd0);
    check("t5_rst_error", 32'(error), 32'd0);
    check("t5_rst_addr", 32'(mem_rd_addr), 32'd0);
    check("t5_rst_chidx", 32'(channel_idx), 32'd0);
    check("t5_rst_pixel_out", 32'(pixel_out), 32'd0);

    // 6a: zero channels
    snap();
    pulse_start(20'h000, 10'd0);
    wait_done("t6", 2);
    check("t6_no_reads", 32'(rd_n - s_rd), 32'd0);
    check("t6_no_frames", 32'(sf_n - s_sf), 32'd0);
    check("t6_done", 32'(done_n - s_done), 32'd1);

    // 6b: start while busy is ignored
    snap(); q0 = rd_addrs.size();
    pulse_start(20'h300, 10'd1);
    repeat (5) @(posedge clock);
    #1 start = 1'b1; base_addr = 20'h000; num_channels = 10'd3;
    @(posedge clock); #1 start = 1'b0;
    wait_done("t6b", 40);
    check("t6b_frames", 32'(sf_n - s_sf), 32'd1);
    check("t6b_reads", 32'(rd_n - s_rd), 32'd16);
    check_addrs("t6b_addr_seq", q0, 20'h300, 16);
    check("t6b_busy_cycles", 32'(busy_n - s_busy), 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
